// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the timer tick scheduler: FSM states,
// timer register map, control words and the load-value helper.
package timer_sched_pkg;

    // One state per timer write, plus the idle/run/ack resting states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_STOP = 3'd1,
        W_PL   = 3'd2,
        W_PH   = 3'd3,
        W_CTRL = 3'd4,
        RUN    = 3'd5,
        ACK    = 3'd6,
        HALT   = 3'd7
    } sched_state_t;

    // Timer register addresses.
    localparam logic [2:0] TMR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_PERIODL = 3'd2;
    localparam logic [2:0] TMR_PERIODH = 3'd3;

    // Control words: ITO|CONT|START to run, STOP to halt.
    localparam logic [15:0] CTRL_RUN  = 16'h0007;
    localparam logic [15:0] CTRL_STOP = 16'h0008;

    // Timer load value: the timer counts L..0, so L = period - 1,
    // with the period clamped from below.
    function automatic logic [31:0] load_value(input logic [31:0] period,
                                               input logic [31:0] min_period);
        logic [31:0] p;
        p = (period < min_period) ? min_period : period;
        return p - 32'd1;
    endfunction

endpackage

// File: rtl/tick_alarm_channel.sv
// One periodic software alarm: divides the shared hardware tick by a
// programmable reload value and pulses fire for one cycle on expiry.
module tick_alarm_channel (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        arm,
    input  logic [15:0] divisor,
    input  logic        tick,
    output logic        active,
    output logic        fire
);

    logic [15:0] reload;
    logic [15:0] remaining;

    // Arm (re)loads or disarms; otherwise count ticks and reload on expiry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reload    <= 16'd0;
            remaining <= 16'd0;
            active    <= 1'b0;
            fire      <= 1'b0;
        end else begin
            fire <= 1'b0;
            if (arm) begin
                if (divisor != 16'd0) begin
                    reload    <= divisor;
                    remaining <= divisor;
                    active    <= 1'b1;
                end else begin
                    active <= 1'b0;
                end
            end else if (tick && active) begin
                if (remaining == 16'd1) begin
                    fire      <= 1'b1;
                    remaining <= reload;
                end else begin
                    remaining <= remaining - 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/timer_tick_scheduler.sv
// Avalon-MM write-only master that programs an interval timer, services
// its irq, counts ticks and fans the tick out to N_CH alarm channels.
// The current FSM state is kept in the enum signal 'state' for observation.
module timer_tick_scheduler
    import timer_sched_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int MIN_PERIOD = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          cfg_period,
    input  logic                 cfg_start,
    input  logic                 cfg_stop,
    output logic                 busy,
    output logic                 running,
    output logic [31:0]          tick_count,
    input  logic [N_CH-1:0]      ch_arm,
    input  logic [16*N_CH-1:0]   ch_ticks,
    output logic [N_CH-1:0]      ch_active,
    output logic [N_CH-1:0]      ch_fire,
    output logic [2:0]           tmr_address,
    output logic                 tmr_chipselect,
    output logic                 tmr_write_n,
    output logic [15:0]          tmr_writedata,
    input  logic                 tmr_irq
);

    localparam logic [31:0] MIN_P = 32'(MIN_PERIOD);

    sched_state_t state;
    sched_state_t state_nxt;
    logic [31:0]  load_q;
    logic         tick_event;

    // Next state; in RUN a restart beats a stop, which beats an irq.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cfg_start) state_nxt = W_STOP;
            W_STOP:  state_nxt = W_PL;
            W_PL:    state_nxt = W_PH;
            W_PH:    state_nxt = W_CTRL;
            W_CTRL:  state_nxt = RUN;
            RUN: begin
                if (cfg_start)     state_nxt = W_STOP;
                else if (cfg_stop) state_nxt = HALT;
                else if (tmr_irq)  state_nxt = ACK;
            end
            ACK:     state_nxt = RUN;
            HALT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM register; bus and status outputs are registered from the next
    // state so each write appears in the cycle its state is occupied.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            load_q         <= 32'd0;
            tick_count     <= 32'd0;
            busy           <= 1'b0;
            running        <= 1'b0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_address    <= 3'd0;
            tmr_writedata  <= 16'd0;
        end else begin
            state <= state_nxt;

            if ((state == IDLE || state == RUN) && cfg_start) begin
                load_q <= load_value(cfg_period, MIN_P);
            end

            if (state_nxt == W_PL) begin
                tick_count <= 32'd0;
            end else if (state == ACK) begin
                tick_count <= tick_count + 32'd1;
            end

            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_address    <= 3'd0;
            tmr_writedata  <= 16'd0;
            case (state_nxt)
                W_STOP, HALT: begin
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= TMR_CONTROL;
                    tmr_writedata  <= CTRL_STOP;
                end
                W_PL: begin
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= TMR_PERIODL;
                    tmr_writedata  <= load_q[15:0];
                end
                W_PH: begin
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= TMR_PERIODH;
                    tmr_writedata  <= load_q[31:16];
                end
                W_CTRL: begin
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= TMR_CONTROL;
                    tmr_writedata  <= CTRL_RUN;
                end
                ACK: begin
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= TMR_STATUS;
                    tmr_writedata  <= 16'd0;
                end
                default: ;
            endcase

            busy    <= (state_nxt == W_STOP) || (state_nxt == W_PL) ||
                       (state_nxt == W_PH)   || (state_nxt == W_CTRL) ||
                       (state_nxt == HALT);
            running <= (state_nxt == RUN) || (state_nxt == ACK);
        end
    end

    // The ACK cycle is the single tick event shared by every channel.
    assign tick_event = (state == ACK);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tick_alarm_channel u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .arm     (ch_arm[i]),
            .divisor (ch_ticks[16*i +: 16]),
            .tick    (tick_event),
            .active  (ch_active[i]),
            .fire    (ch_fire[i])
        );
    end

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Bench for timer_tick_scheduler: a behavioural timer slave drives irq,
// a write-queue reference model predicts every output on every cycle.
module tb_timer_tick_scheduler;

    localparam int N_CH = 4;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [31:0]          cfg_period;
    logic                 cfg_start;
    logic                 cfg_stop;
    logic                 busy;
    logic                 running;
    logic [31:0]          tick_count;
    logic [N_CH-1:0]      ch_arm;
    logic [16*N_CH-1:0]   ch_ticks;
    logic [N_CH-1:0]      ch_active;
    logic [N_CH-1:0]      ch_fire;
    logic [2:0]           tmr_address;
    logic                 tmr_chipselect;
    logic                 tmr_write_n;
    logic [15:0]          tmr_writedata;
    logic                 tmr_irq;

    timer_tick_scheduler #(.N_CH(N_CH), .MIN_PERIOD(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_period     (cfg_period),
        .cfg_start      (cfg_start),
        .cfg_stop       (cfg_stop),
        .busy           (busy),
        .running        (running),
        .tick_count     (tick_count),
        .ch_arm         (ch_arm),
        .ch_ticks       (ch_ticks),
        .ch_active      (ch_active),
        .ch_fire        (ch_fire),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model: writes still to be issued, the write on the bus now,
    // whether the scheduler is (or returns to) the running condition.
    logic [18:0] exp_q[$];
    bit          cur_v;
    logic [18:0] cur_w;
    bit          run_f;
    bit          after_run;
    logic [31:0] m_ticks;
    logic [15:0] m_rel[N_CH];
    logic [15:0] m_rem[N_CH];
    bit          m_act[N_CH];
    logic [N_CH-1:0] m_fire;

    // Behavioural timer slave.
    logic [31:0] t_per, t_cnt;
    bit          t_run, t_to, t_ito, t_cont;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fire_cnt[N_CH];
    int irq_len, irq_max;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        cur_v = 0; cur_w = '0; run_f = 0; after_run = 0; m_ticks = '0; m_fire = '0;
        for (int i = 0; i < N_CH; i++) begin
            m_rel[i] = '0; m_rem[i] = '0; m_act[i] = 0;
        end
        t_per = '0; t_cnt = '0; t_run = 0; t_to = 0; t_ito = 0; t_cont = 0;
    endtask

    function automatic logic [63:0] bus_now();
        return 64'({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata});
    endfunction

    function automatic logic [63:0] bus_wr(input logic [2:0] a, input logic [15:0] d);
        return 64'({1'b1, 1'b0, a, d});
    endfunction

    task automatic compare_outputs();
        logic [18:0] e_bus;
        logic [N_CH-1:0] act;
        bit e_busy;
        e_bus  = cur_v ? cur_w : 19'd0;
        e_busy = cur_v && (cur_w[18:16] != 3'd0);
        for (int i = 0; i < N_CH; i++) act[i] = m_act[i];
        check("bus", bus_now(), 64'({cur_v, !cur_v, e_bus}));
        check("status", 64'({busy, running, tick_count}), 64'({e_busy, run_f, m_ticks}));
        check("chan", 64'({ch_active, ch_fire}), 64'({act, m_fire}));
    endtask

    // Advance the reference model by one cycle given this cycle's inputs.
    task automatic model_advance(input bit start, input bit stop, input bit irq,
                                 input logic [N_CH-1:0] arm);
        logic [31:0] l;
        logic [15:0] dv;
        bit tick;
        tick = cur_v && (cur_w[18:16] == 3'd0);
        for (int i = 0; i < N_CH; i++) begin
            dv = ch_ticks[16*i +: 16];
            m_fire[i] = 1'b0;
            if (arm[i]) begin
                if (dv != 0) begin m_rel[i] = dv; m_rem[i] = dv; m_act[i] = 1; end
                else m_act[i] = 0;
            end else if (tick && m_act[i]) begin
                if (m_rem[i] == 16'd1) begin m_fire[i] = 1'b1; m_rem[i] = m_rel[i]; end
                else m_rem[i] = m_rem[i] - 16'd1;
            end
        end
        if (cur_v) begin
            if (tick) m_ticks = m_ticks + 1;
            if (exp_q.size() > 0) begin
                cur_w = exp_q.pop_front();
                if (cur_w[18:16] == 3'd2) m_ticks = '0;
            end else begin
                cur_v = 0;
                run_f = after_run;
            end
        end else if (start) begin
            l = ((cfg_period < 32'd8) ? 32'd8 : cfg_period) - 32'd1;
            cur_v = 1; cur_w = {3'd1, 16'h0008};
            exp_q.push_back({3'd2, l[15:0]});
            exp_q.push_back({3'd3, l[31:16]});
            exp_q.push_back({3'd1, 16'h0007});
            run_f = 0; after_run = 1;
        end else if (run_f && stop) begin
            cur_v = 1; cur_w = {3'd1, 16'h0008}; run_f = 0; after_run = 0;
        end else if (run_f && irq) begin
            cur_v = 1; cur_w = {3'd0, 16'h0000}; after_run = 1;
        end
    endtask

    // Timer slave reacts to the write currently on the bus.
    task automatic timer_advance();
        if (t_run) begin
            if (t_cnt == 0) begin
                t_to = 1; t_cnt = t_per;
                if (!t_cont) t_run = 0;
            end else t_cnt = t_cnt - 1;
        end
        if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
                3'd0: t_to = 0;
                3'd1: begin
                    t_ito = tmr_writedata[0]; t_cont = tmr_writedata[1];
                    if (tmr_writedata[3]) t_run = 0;
                    if (tmr_writedata[2]) begin t_run = 1; t_cnt = t_per; end
                end
                3'd2: t_per[15:0]  = tmr_writedata;
                3'd3: t_per[31:16] = tmr_writedata;
                default: ;
            endcase
        end
    endtask

    // Driver: one clock cycle, compare first, then apply inputs and advance.
    task automatic step(input bit start, input bit stop, input logic [N_CH-1:0] arm);
        compare_outputs();
        for (int i = 0; i < N_CH; i++) if (ch_fire[i]) fire_cnt[i]++;
        cfg_start = start;
        cfg_stop  = stop;
        ch_arm    = arm;
        tmr_irq   = t_to && t_ito;
        irq_len   = tmr_irq ? irq_len + 1 : 0;
        if (irq_len > irq_max) irq_max = irq_len;
        model_advance(start, stop, tmr_irq, arm);
        timer_advance();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cfg_start = 0; cfg_stop = 0; ch_arm = '0; tmr_irq = 0;
        model_reset();
        @(negedge clk);
        check("reset_outputs",
              64'({busy, running, tick_count, ch_active, ch_fire,
                   tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}),
              64'({1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b1, 3'd0, 16'd0}));
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] pick_period();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 10));
            1:       return 32'($urandom_range(11, 60));
            2:       return 32'($urandom_range(61, 200));
            default: return 32'h0001_0000 + 32'($urandom_range(0, 9));
        endcase
    endfunction

    initial begin
        int c0, n, wr_seen;
        cfg_period = 32'd0; ch_ticks = '0;
        for (int i = 0; i < N_CH; i++) fire_cnt[i] = 0;
        irq_len = 0; irq_max = 0;
        do_reset();
        step(0, 0, '0);
        step(0, 1, '0);          // stop in IDLE: ignored

        // Programming sequence for period 50000 (L = 49999 = 0xC34F).
        cfg_period = 32'd50000;
        step(1, 0, '0);
        check("seq_stop", bus_now(), bus_wr(3'd1, 16'h0008));
        step(0, 0, '0);
        check("seq_pl", bus_now(), bus_wr(3'd2, 16'hC34F));
        step(0, 0, '0);
        check("seq_ph", bus_now(), bus_wr(3'd3, 16'h0000));
        step(0, 0, '0);
        check("seq_ctrl", bus_now(), bus_wr(3'd1, 16'h0007));
        step(0, 0, '0);
        check("seq_run", 64'({busy, running}), 64'(2'b01));
        step(0, 1, '0);
        check("halt_write", bus_now(), bus_wr(3'd1, 16'h0008));
        step(0, 0, '0);
        check("halt_idle", 64'({busy, running, tmr_chipselect}), 64'd0);

        // Period 100: ten ticks serviced by cycle 1010 after start.
        cfg_period = 32'd100;
        c0 = cyc;
        step(1, 0, '0);
        irq_max = 0;
        while (cyc - c0 < 1010) step(0, 0, '0);
        check("ticks_at_1010", 64'(tick_count), 64'd10);
        check("irq_len_max", 64'(irq_max <= 2), 64'd1);

        // Clamp: period 3 is programmed as load 7; restart from RUN.
        cfg_period = 32'd3;
        c0 = cyc;
        step(1, 0, '0);
        step(0, 0, '0);
        check("clamp_pl", bus_now(), bus_wr(3'd2, 16'h0007));
        step(0, 0, '0); step(0, 0, '0); step(0, 0, '0);
        for (int i = 0; i < N_CH; i++) fire_cnt[i] = 0;
        ch_ticks = {16'd0, 16'd0, 16'd1, 16'd3};
        step(0, 0, 4'b0011);
        n = 0;
        while (m_ticks < 9 && n < 200) begin step(0, 0, '0); n++; end
        check("wait_9_ticks", 64'(n < 200), 64'd1);
        step(0, 0, '0);
        check("ch0_fires", 64'(fire_cnt[0]), 64'd3);
        check("ch1_fires", 64'(fire_cnt[1]), 64'd9);
        ch_ticks[15:0] = 16'd0;
        step(0, 0, 4'b0001);
        check("ch0_disarm", 64'(ch_active[0]), 64'd0);
        n = 0;
        while (m_ticks < 100 && n < 1000) begin step(0, 0, '0); n++; end
        check("ticks_100", 64'(tick_count), 64'd100);
        check("tick_100_cycle", 64'(cyc - c0), 64'd807);
        check("ch0_quiet", 64'(fire_cnt[0]), 64'd3);

        // Stop with an irq pending: no ack, then restart clears the count.
        ch_ticks[15:0] = 16'd5;
        step(0, 0, 4'b0001);
        n = 0;
        while (!(t_to && t_ito && run_f && !cur_v) && n < 100) begin step(0, 0, '0); n++; end
        check("stop_setup", 64'(n < 100), 64'd1);
        step(0, 1, '0);
        check("stop_write", bus_now(), bus_wr(3'd1, 16'h0008));
        check("stop_status", 64'({busy, running}), 64'(2'b10));
        step(0, 0, '0);
        check("stop_idle", 64'({busy, running, tmr_chipselect}), 64'd0);
        for (int k = 0; k < 20; k++) step(0, 0, '0);
        step(1, 0, '0);
        step(0, 0, '0);
        check("restart_count", 64'(tick_count), 64'd0);
        for (int k = 0; k < 40; k++) step(0, 0, '0);

        // Reset during W_PH: outputs return to reset values, bus stays idle.
        step(1, 0, '0);
        step(0, 0, '0);
        step(0, 0, '0);
        check("pre_reset_ph", 64'(tmr_address), 64'd3);
        do_reset();
        wr_seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (tmr_chipselect) wr_seen++;
            step(0, 0, '0);
        end
        check("no_writes_after_reset", 64'(wr_seen), 64'd0);

        // Randomized traffic against the reference model.
        cfg_period = 32'd20;
        step(1, 0, '0);
        for (int k = 0; k < 4000; k++) begin
            logic [N_CH-1:0] arm;
            if ($urandom_range(0, 3) == 0) cfg_period = pick_period();
            for (int i = 0; i < N_CH; i++) begin
                arm[i] = ($urandom_range(0, 24) == 0);
                ch_ticks[16*i +: 16] = 16'($urandom_range(0, 4));
            end
            step($urandom_range(0, 249) == 0, $urandom_range(0, 299) == 0, arm);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
